// File: rtl/mastermind_pkg.sv
// Shared types and width helpers for the mastermind game core.
// Default-configuration widths are exported for anything sized at the defaults.
package mastermind_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTER,
        ST_SCORE_EXACT,
        ST_SCORE_COLOR,
        ST_WON,
        ST_LOST
    } mm_state_t;

    localparam int DEF_NUM_PEGS  = 4;
    localparam int DEF_COLOR_W   = 3;
    localparam int DEF_MAX_TURNS = 8;

    // Bits needed to hold a count from 0 up to and including max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int PEG_CNT_W = $clog2(DEF_NUM_PEGS + 1);
    localparam int TURN_W    = $clog2(DEF_MAX_TURNS + 1);

endpackage

// File: rtl/mastermind_if.sv
// Secret-code load handshake between the code source (PRNG) and the game core.
interface mastermind_if #(
    parameter int CODE_W = 12
);
    logic [CODE_W-1:0] code_in;
    logic              code_valid;
    logic              code_ready;

    modport master (output code_in, output code_valid, input code_ready);
    modport slave  (input code_in, input code_valid, output code_ready);
endinterface

// File: rtl/mm_scorer.sv
// Sequential black/white scorer: one peg per cycle, then one colour per cycle.
// done, black and white are valid together in the final colour cycle.
module mm_scorer
    import mastermind_pkg::*;
#(
    parameter int NUM_PEGS = 4,
    parameter int COLOR_W  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_PEGS*COLOR_W-1:0]   code,
    input  logic [NUM_PEGS*COLOR_W-1:0]   guess,
    output logic                          exact_done,
    output logic                          done,
    output logic [cnt_w(NUM_PEGS)-1:0]    black,
    output logic [cnt_w(NUM_PEGS)-1:0]    white
);
    localparam int NUM_COLORS = 1 << COLOR_W;
    localparam int PC_W       = cnt_w(NUM_PEGS);
    localparam int STEP_W     = $clog2((NUM_COLORS > NUM_PEGS) ? NUM_COLORS : NUM_PEGS);

    logic              exact_ph, color_ph;
    logic [STEP_W-1:0] step;
    logic [PC_W-1:0]   code_cnt  [NUM_COLORS];
    logic [PC_W-1:0]   guess_cnt [NUM_COLORS];
    logic [PC_W-1:0]   black_acc, sum_acc, sum_next, cc, gc;
    logic [COLOR_W-1:0] code_peg, guess_peg;

    always_comb begin
        code_peg  = code[step*COLOR_W +: COLOR_W];
        guess_peg = guess[step*COLOR_W +: COLOR_W];
        cc        = code_cnt[step[COLOR_W-1:0]];
        gc        = guess_cnt[step[COLOR_W-1:0]];
        sum_next  = sum_acc + ((cc < gc) ? cc : gc);
    end

    assign exact_done = exact_ph && (step == '0);
    assign done       = color_ph && (step == '0);
    assign black      = black_acc;
    assign white      = sum_next - black_acc;

    // Pegs and colours are walked from the top index down so step is a plain down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact_ph  <= 1'b0;
            color_ph  <= 1'b0;
            step      <= '0;
            black_acc <= '0;
            sum_acc   <= '0;
            for (int i = 0; i < NUM_COLORS; i++) begin
                code_cnt[i]  <= '0;
                guess_cnt[i] <= '0;
            end
        end else if (start && !exact_ph && !color_ph) begin
            exact_ph  <= 1'b1;
            step      <= STEP_W'(NUM_PEGS - 1);
            black_acc <= '0;
            sum_acc   <= '0;
            for (int i = 0; i < NUM_COLORS; i++) begin
                code_cnt[i]  <= '0;
                guess_cnt[i] <= '0;
            end
        end else if (exact_ph) begin
            if (code_peg == guess_peg) black_acc <= black_acc + PC_W'(1);
            code_cnt[code_peg]   <= code_cnt[code_peg] + PC_W'(1);
            guess_cnt[guess_peg] <= guess_cnt[guess_peg] + PC_W'(1);
            if (step == '0) begin
                exact_ph <= 1'b0;
                color_ph <= 1'b1;
                step     <= STEP_W'(NUM_COLORS - 1);
            end else begin
                step <= step - STEP_W'(1);
            end
        end else if (color_ph) begin
            sum_acc <= sum_next;
            if (step == '0) color_ph <= 1'b0;
            else            step     <= step - STEP_W'(1);
        end
    end

endmodule

// File: rtl/mastermind_core.sv
// Mastermind game controller: guess editing, scoring sequence, history and end-of-game flags.
//   state          | meaning
//   ST_IDLE        | waiting for a secret code, code_ready high
//   ST_ENTER       | editing guess (mode 0) or reviewing history (mode 1)
//   ST_SCORE_EXACT | scorer walking pegs, buttons ignored
//   ST_SCORE_COLOR | scorer walking colours, buttons ignored
//   ST_WON         | last guess was all black, select returns to idle
//   ST_LOST        | turns exhausted, select returns to idle
module mastermind_core
    import mastermind_pkg::*;
#(
    parameter int NUM_PEGS  = 4,
    parameter int COLOR_W   = 3,
    parameter int MAX_TURNS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mastermind_if.slave                   code_bus,
    input  logic                          mode,
    input  logic                          select,
    input  logic                          left,
    input  logic                          right,
    input  logic                          up,
    input  logic                          down,
    output logic [NUM_PEGS*COLOR_W-1:0]   guess_out,
    output logic [$clog2(NUM_PEGS)-1:0]   cursor,
    output logic [NUM_PEGS*COLOR_W-1:0]   hist_out,
    output logic [cnt_w(NUM_PEGS)-1:0]    hist_black,
    output logic [cnt_w(NUM_PEGS)-1:0]    hist_white,
    output logic [$clog2(MAX_TURNS)-1:0]  hist_idx,
    output logic [cnt_w(MAX_TURNS)-1:0]   turn_count,
    output logic                          busy,
    output logic                          won,
    output logic                          lost
);
    localparam int CODE_W = NUM_PEGS * COLOR_W;
    localparam int CUR_W  = $clog2(NUM_PEGS);
    localparam int HI_W   = $clog2(MAX_TURNS);
    localparam int TC_W   = cnt_w(MAX_TURNS);
    localparam int PC_W   = cnt_w(NUM_PEGS);

    mm_state_t          state, next_state;
    logic [CODE_W-1:0]  secret, guess;
    logic [CUR_W-1:0]   cur;
    logic [HI_W-1:0]    hidx, wr_idx;
    logic [TC_W-1:0]    turns;
    logic [CODE_W-1:0]  hist_code [MAX_TURNS];
    logic [PC_W-1:0]    hist_blk  [MAX_TURNS];
    logic [PC_W-1:0]    hist_wht  [MAX_TURNS];
    logic               score_start, exact_done, score_done;
    logic [PC_W-1:0]    black, white;
    logic               load, edit, review;

    assign wr_idx = turns[HI_W-1:0];
    assign load   = code_bus.code_valid && code_bus.code_ready;
    assign edit   = (state == ST_ENTER) && !mode;
    assign review = mode && (state == ST_ENTER || state == ST_WON || state == ST_LOST);

    mm_scorer #(.NUM_PEGS(NUM_PEGS), .COLOR_W(COLOR_W)) u_scorer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (score_start),
        .code       (secret),
        .guess      (guess),
        .exact_done (exact_done),
        .done       (score_done),
        .black      (black),
        .white      (white)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state          = state;
        code_bus.code_ready = 1'b0;
        busy                = 1'b0;
        won                 = 1'b0;
        lost                = 1'b0;
        score_start         = 1'b0;
        case (state)
            ST_IDLE: begin
                code_bus.code_ready = 1'b1;
                if (code_bus.code_valid) next_state = ST_ENTER;
            end
            ST_ENTER: begin
                if (!mode && select) begin
                    score_start = 1'b1;
                    next_state  = ST_SCORE_EXACT;
                end
            end
            ST_SCORE_EXACT: begin
                busy = 1'b1;
                if (exact_done) next_state = ST_SCORE_COLOR;
            end
            ST_SCORE_COLOR: begin
                busy = 1'b1;
                if (score_done) begin
                    if (black == PC_W'(NUM_PEGS))          next_state = ST_WON;
                    else if (turns == TC_W'(MAX_TURNS - 1)) next_state = ST_LOST;
                    else                                    next_state = ST_ENTER;
                end
            end
            ST_WON: begin
                won = 1'b1;
                if (select) next_state = ST_IDLE;
            end
            ST_LOST: begin
                lost = 1'b1;
                if (select) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            secret <= '0;
            guess  <= '0;
            cur    <= '0;
            hidx   <= '0;
            turns  <= '0;
            for (int i = 0; i < MAX_TURNS; i++) begin
                hist_code[i] <= '0;
                hist_blk[i]  <= '0;
                hist_wht[i]  <= '0;
            end
        end else if (load) begin
            secret <= code_bus.code_in;
            guess  <= '0;
            cur    <= '0;
            hidx   <= '0;
            turns  <= '0;
            for (int i = 0; i < MAX_TURNS; i++) begin
                hist_code[i] <= '0;
                hist_blk[i]  <= '0;
                hist_wht[i]  <= '0;
            end
        end else if (edit) begin
            if (select) begin
                hist_code[wr_idx] <= guess;
            end else if (left) begin
                cur <= (cur == '0) ? CUR_W'(NUM_PEGS - 1) : cur - CUR_W'(1);
            end else if (right) begin
                cur <= (cur == CUR_W'(NUM_PEGS - 1)) ? '0 : cur + CUR_W'(1);
            end else if (up) begin
                guess[cur*COLOR_W +: COLOR_W] <= guess[cur*COLOR_W +: COLOR_W] + COLOR_W'(1);
            end else if (down) begin
                guess[cur*COLOR_W +: COLOR_W] <= guess[cur*COLOR_W +: COLOR_W] - COLOR_W'(1);
            end
        end else if (review) begin
            // Saturate at the newest scored entry; stays 0 when nothing is scored yet.
            if (up) begin
                if (TC_W'(hidx) + TC_W'(1) < turns) hidx <= hidx + HI_W'(1);
            end else if (down) begin
                if (hidx != '0) hidx <= hidx - HI_W'(1);
            end
        end else if (state == ST_SCORE_COLOR && score_done) begin
            hist_blk[wr_idx] <= black;
            hist_wht[wr_idx] <= white;
            turns            <= turns + TC_W'(1);
        end
    end

    assign guess_out  = guess;
    assign cursor     = cur;
    assign hist_idx   = hidx;
    assign turn_count = turns;
    assign hist_out   = hist_code[hidx];
    assign hist_black = hist_blk[hidx];
    assign hist_white = hist_wht[hidx];

endmodule
